// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer and the decode stage.
// Contents:
//   fmt_e        instruction format codes reported on fmt (0 unknown .. 5 UJ)
//   OP_*         7-bit major opcodes that select a format
//   fsm_state_e  fetch sequencer state encoding
package instr_fetch_seq_pkg;

  typedef enum logic [2:0] {
    FMT_UNK = 3'd0,
    FMT_R   = 3'd1,
    FMT_I   = 3'd2,
    FMT_S   = 3'd3,
    FMT_SB  = 3'd4,
    FMT_UJ  = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } fsm_state_e;

endpackage

// File: rtl/instr_fmt_classify.sv
// Combinational opcode -> instruction format classifier.
// Shared between the fetch sequencer and the decode stage.
// Ports:
//   opcode_i  in   7  instruction bits [6:0]
//   fmt_o     out  3  format code (FMT_UNK for any unrecognised opcode)
module instr_fmt_classify
  import instr_fetch_seq_pkg::*;
(
  input  logic [6:0] opcode_i,
  output fmt_e       fmt_o
);

  // Loads and ALU-immediate ops share the I format.
  always_comb begin
    fmt_o = FMT_UNK;
    case (opcode_i)
      OP_R:            fmt_o = FMT_R;
      OP_LOAD, OP_IMM: fmt_o = FMT_I;
      OP_STORE:        fmt_o = FMT_S;
      OP_BRANCH:       fmt_o = FMT_SB;
      OP_JAL:          fmt_o = FMT_UJ;
      default:         fmt_o = FMT_UNK;
    endcase
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: walks PC from a base address in steps of 4,
// issues one memory read per word, classifies the returned word and hands it
// downstream with a valid/ready handshake.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   start_i                   begin a run (only looked at in IDLE)
//   base_sel_i, base_addr_i   0: start at START_ADDR, 1: start at base_addr_i
//   count_i                   number of words to fetch
//   abort_i                   cancel the run, return to IDLE without done
//   mem_addr_o, mem_read_o    read request; mem_write_o is always 0
//   mem_rdata_i               read data, valid MEM_LAT cycles after the request
//   instr_valid_o/ready_i     downstream handshake for instr_o/fmt_o/pc_out_o
//   busy_o, done_o            run in progress / one-cycle completion pulse
//   illegal_o                 an unknown-format word was delivered this run
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h28,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             base_sel_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             abort_i,
  output logic [31:0]      mem_addr_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  input  logic [31:0]      mem_rdata_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_o,
  output logic [2:0]       fmt_o,
  output logic [31:0]      pc_out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             illegal_o
);

  // The wait counter only ever holds 0 .. MEM_LAT-1.
  localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  fsm_state_e       state_q;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] remaining_q;
  logic [LAT_W-1:0] lat_cnt_q;
  logic [31:0]      mem_addr_q, instr_q, pc_out_q, start_pc;
  logic             mem_read_q, instr_valid_q, busy_q, done_q, illegal_q;
  fmt_e             fmt_q, fmt_w;

  instr_fmt_classify u_classify (
    .opcode_i (mem_rdata_i[6:0]),
    .fmt_o    (fmt_w)
  );

  // Wraps naturally at 2^32; the base address is forced word aligned.
  assign pc_d     = pc_q + 32'd4;
  assign start_pc = base_sel_i ? {base_addr_i[31:2], 2'b00} : START_ADDR;

  // All outputs are registered and updated on the transition into the state
  // where they must be visible; abort overrides every other transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      remaining_q   <= '0;
      lat_cnt_q     <= '0;
      mem_addr_q    <= '0;
      mem_read_q    <= 1'b0;
      instr_q       <= '0;
      fmt_q         <= FMT_UNK;
      pc_out_q      <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q       <= S_IDLE;
        mem_read_q    <= 1'b0;
        instr_valid_q <= 1'b0;
        busy_q        <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              pc_q        <= start_pc;
              remaining_q <= count_i;
              illegal_q   <= 1'b0;
              busy_q      <= 1'b1;
              if (count_i == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q    <= S_REQ;
                mem_addr_q <= start_pc;
                mem_read_q <= 1'b1;
              end
            end
          end
          S_REQ: begin
            lat_cnt_q <= LAT_INIT;
            state_q   <= S_WAIT;
          end
          S_WAIT: begin
            if (lat_cnt_q == '0) begin
              instr_q       <= mem_rdata_i;
              fmt_q         <= fmt_w;
              pc_out_q      <= pc_q;
              mem_read_q    <= 1'b0;
              instr_valid_q <= 1'b1;
              state_q       <= S_HOLD;
            end else begin
              lat_cnt_q <= lat_cnt_q - 1'b1;
            end
          end
          S_HOLD: begin
            // instr_valid is always 1 here, so ready alone completes the handshake.
            if (instr_ready_i) begin
              instr_valid_q <= 1'b0;
              pc_q          <= pc_d;
              remaining_q   <= remaining_q - 1'b1;
              if (fmt_q == FMT_UNK) begin
                illegal_q <= 1'b1;
              end
              if (remaining_q == CNT_W'(1)) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q    <= S_REQ;
                mem_addr_q <= pc_d;
                mem_read_q <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_addr_o    = mem_addr_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = 1'b0;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign fmt_o         = fmt_q;
  assign pc_out_o      = pc_out_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: a latency-enforcing memory model,
// and a scoreboard of expected {pc, word, fmt} filled when a run is started
// and drained on every instr_valid/instr_ready handshake.
module tb_instr_fetch_seq;

  localparam int unsigned MEM_LAT    = 3;
  localparam logic [31:0] START_ADDR = 32'h28;
  localparam logic [31:0] JUNK       = 32'h5555_5555;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic [2:0]  fmt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN, start, baseSel, abort, instrReady;
  logic [31:0] baseAddr;
  logic [7:0]  count;
  logic [31:0] memAddr, memRdata, instr, pcOut;
  logic        memRead, memWrite, instrValid, busy, done, illegal;
  logic [2:0]  fmt;

  logic [31:0] memArr [256];
  int          rdCycles;
  exp_t        expQ [$];
  exp_t        expItem;
  int          vecCount = 0;
  int          errCount = 0;
  int          doneCount = 0;

  always #5 clk = ~clk;

  instr_fetch_seq #(
    .START_ADDR (START_ADDR),
    .MEM_LAT    (MEM_LAT),
    .CNT_W      (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .start_i       (start),
    .base_sel_i    (baseSel),
    .base_addr_i   (baseAddr),
    .count_i       (count),
    .abort_i       (abort),
    .mem_addr_o    (memAddr),
    .mem_read_o    (memRead),
    .mem_write_o   (memWrite),
    .mem_rdata_i   (memRdata),
    .instr_valid_o (instrValid),
    .instr_ready_i (instrReady),
    .instr_o       (instr),
    .fmt_o         (fmt),
    .pc_out_o      (pcOut),
    .busy_o        (busy),
    .done_o        (done),
    .illegal_o     (illegal)
  );

  // Memory returns real data only once mem_read has been held MEM_LAT cycles.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) rdCycles <= 0;
    else       rdCycles <= memRead ? rdCycles + 1 : 0;
  end
  assign memRdata = (memRead && rdCycles >= int'(MEM_LAT)) ? memArr[memAddr[9:2]] : JUNK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    vecCount++;
    if (obs !== expVal) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expVal);
    end
  endtask

  function automatic logic [2:0] refFmt(input logic [31:0] w);
    case (w[6:0])
      7'h33:        return 3'd1;
      7'h03, 7'h13: return 3'd2;
      7'h23:        return 3'd3;
      7'h63:        return 3'd4;
      7'h6F:        return 3'd5;
      default:      return 3'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes the expected stream for this run, then pulses start for one cycle.
  task automatic applyStimulus(input logic sel, input logic [31:0] base, input logic [7:0] cnt);
    logic [31:0] pc;
    exp_t        e;
    pc = sel ? {base[31:2], 2'b00} : START_ADDR;
    for (int i = 0; i < int'(cnt); i++) begin
      e.pc   = pc;
      e.word = memArr[pc[9:2]];
      e.fmt  = refFmt(e.word);
      expQ.push_back(e);
      pc = pc + 32'd4;
    end
    baseSel  = sel;
    baseAddr = base;
    count    = cnt;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic waitDone(input int prevDone, input int budget);
    int n = 0;
    while (doneCount == prevDone && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done_within_budget", 32'(doneCount != prevDone), 32'd1);
    repeat (3) tick();
    checkOutput("done_pulse_count", 32'(doneCount - prevDone), 32'd1);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    checkOutput("busy_after_run", 32'(busy), 32'd0);
  endtask

  // Scoreboard side: every handshake must match the head of the queue.
  always @(negedge clk) begin
    if (rstN) begin
      if (instrValid && instrReady) begin
        checkOutput("scoreboard_has_entry", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          expItem = expQ.pop_front();
          checkOutput("pc_out", pcOut, expItem.pc);
          checkOutput("instr", instr, expItem.word);
          checkOutput("fmt", 32'(fmt), 32'(expItem.fmt));
        end
        checkOutput("mem_write", 32'(memWrite), 32'd0);
      end
      if (done) doneCount++;
    end
  end

  initial begin
    int prev;
    int n;
    rstN = 1'b0; start = 1'b0; baseSel = 1'b0; baseAddr = '0;
    count = '0; abort = 1'b0; instrReady = 1'b0;
    for (int i = 0; i < 256; i++) memArr[i] = 32'(i) * 32'h9E37_79B1 + 32'h13;

    // Reset values
    repeat (2) tick();
    checkOutput("rst_mem_addr", memAddr, 32'd0);
    checkOutput("rst_mem_read", 32'(memRead), 32'd0);
    checkOutput("rst_mem_write", 32'(memWrite), 32'd0);
    checkOutput("rst_instr_valid", 32'(instrValid), 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_fmt", 32'(fmt), 32'd0);
    checkOutput("rst_pc_out", pcOut, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    rstN = 1'b1;
    tick();

    // Default base, 11 words, ready always high
    $display("[TB] run: default base, count=11");
    instrReady = 1'b1;
    prev = doneCount;
    applyStimulus(1'b0, 32'h0, 8'd11);
    checkOutput("busy_in_run", 32'(busy), 32'd1);
    waitDone(prev, 300);

    // One word of each known format; misaligned base is forced to 0x100
    $display("[TB] run: format mix");
    memArr[64] = 32'h00A0_0093;
    memArr[65] = 32'h0020_81B3;
    memArr[66] = 32'h0031_A023;
    memArr[67] = 32'hFE00_0EE3;
    memArr[68] = 32'h0000_006F;
    prev = doneCount;
    applyStimulus(1'b1, 32'h103, 8'd5);
    waitDone(prev, 200);
    checkOutput("illegal_clean_run", 32'(illegal), 32'd0);

    // Unknown word sets the sticky illegal flag
    $display("[TB] run: illegal word");
    memArr[128] = 32'hFFFF_FFFF;
    prev = doneCount;
    applyStimulus(1'b1, 32'h200, 8'd1);
    waitDone(prev, 100);
    checkOutput("illegal_set", 32'(illegal), 32'd1);
    repeat (5) tick();
    checkOutput("illegal_sticky", 32'(illegal), 32'd1);

    // Stalled downstream, first-word latency and illegal clear on start
    $display("[TB] run: ready stall");
    instrReady = 1'b0;
    prev = doneCount;
    applyStimulus(1'b0, 32'h0, 8'd2);
    checkOutput("illegal_cleared", 32'(illegal), 32'd0);
    n = 1;
    while (!instrValid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("first_latency", 32'(n), 32'(2 + MEM_LAT));
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 32'(instrValid), 32'd1);
      checkOutput("stall_mem_read", 32'(memRead), 32'd0);
      checkOutput("stall_pc_out", pcOut, START_ADDR);
      checkOutput("stall_instr", instr, memArr[START_ADDR[9:2]]);
      tick();
    end
    instrReady = 1'b1;
    waitDone(prev, 100);

    // Address wrap past 0xFFFFFFFC
    $display("[TB] run: wrap");
    memArr[255] = 32'h0000_0013;
    memArr[0]   = 32'h0000_0033;
    prev = doneCount;
    applyStimulus(1'b1, 32'hFFFF_FFFC, 8'd2);
    waitDone(prev, 100);

    // count=0 completes immediately without a memory read
    $display("[TB] run: zero count");
    prev = doneCount;
    applyStimulus(1'b0, 32'h0, 8'd0);
    checkOutput("cnt0_done", 32'(done), 32'd1);
    checkOutput("cnt0_busy", 32'(busy), 32'd1);
    checkOutput("cnt0_mem_read", 32'(memRead), 32'd0);
    tick();
    checkOutput("cnt0_done_drop", 32'(done), 32'd0);
    checkOutput("cnt0_busy_drop", 32'(busy), 32'd0);
    checkOutput("cnt0_pulses", 32'(doneCount - prev), 32'd1);

    // Abort while waiting on memory
    $display("[TB] run: abort in WAIT");
    prev = doneCount;
    applyStimulus(1'b0, 32'h0, 8'd3);
    tick();
    checkOutput("wait_mem_read", 32'(memRead), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_mem_read", 32'(memRead), 32'd0);
    repeat (8) tick();
    checkOutput("abort_no_valid", 32'(instrValid), 32'd0);
    checkOutput("abort_no_done", 32'(doneCount - prev), 32'd0);
    expQ.delete();

    // Abort and start together in IDLE: abort wins
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort_start_busy", 32'(busy), 32'd0);
    checkOutput("abort_start_mem_read", 32'(memRead), 32'd0);

    // Reset asserted while holding a word
    $display("[TB] run: reset in HOLD");
    instrReady = 1'b0;
    prev = doneCount;
    applyStimulus(1'b0, 32'h0, 8'd1);
    n = 0;
    while (!instrValid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("hold_reached", 32'(instrValid), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(instrValid), 32'd0);
    checkOutput("rst_async_busy", 32'(busy), 32'd0);
    checkOutput("rst_async_pc_out", pcOut, 32'd0);
    expQ.delete();
    repeat (2) tick();
    rstN = 1'b1;
    instrReady = 1'b1;
    repeat (3) tick();
    checkOutput("rst_no_done", 32'(doneCount - prev), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
